// File: rtl/neuron_mac_array.sv
// neuron_mac_array: multi-lane pipelined multiply-accumulate engine for one
// neuron output. Each accepted beat carries LANES weight/activation pairs with
// a per-lane enable mask. The masked products are summed and accumulated onto
// a preloaded bias. The final sum is rounded half-up, rescaled by FRAC and
// saturated to N bits.
//
// Optional feature macro: NEURON_MAC_RELU_EN
//   defined   : a negative saturated result is forced to zero (ReLU). sat still
//               reports clipping at the negative limit.
//   undefined : the signed result passes through unchanged.
//
// Pipeline, counted from the edge that accepts a beat:
//   P1 masked products -> P2 adder-tree sum -> P3 accumulate
//   -> round/shift register -> saturated output register.
// With no output stall, out_valid rises four edges after the last beat.

module neuron_mac_array #(
  parameter int N     = 16,
  parameter int FRAC  = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N-1:0]       bias,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [LANES-1:0]   in_mask,
  input  logic [LANES*N-1:0] weight,
  input  logic [LANES*N-1:0] data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_data,
  output logic               sat,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } state_t;

  // The rounding constant is 2^(FRAC-1). It is zero when FRAC is 0, so the
  // shift below then leaves the accumulator unchanged.
  localparam int HALF_SH = (FRAC > 0) ? (FRAC - 1) : 0;
  localparam logic signed [ACC_W-1:0] HALF =
    (FRAC > 0) ? (ACC_W'(1) << HALF_SH) : '0;

  // Output clipping limits, sign-extended to accumulator width
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (N - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  state_t state_q, state_d;

  // P1: masked lane products
  logic signed [2*N-1:0] p1Prod_q [LANES];
  logic signed [2*N-1:0] p1Prod_d [LANES];
  logic                  p1Valid_q, p1Valid_d;
  logic                  p1Last_q,  p1Last_d;

  // P2: adder-tree sum
  logic signed [ACC_W-1:0] p2Sum_q, p2Sum_d;
  logic                    p2Valid_q, p2Valid_d;
  logic                    p2Last_q,  p2Last_d;

  // P3: accumulator
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    accDone_q, accDone_d;

  // Rounded and rescaled accumulator
  logic signed [ACC_W-1:0] rnd_q, rnd_d;
  logic                    rndValid_q, rndValid_d;

  // Result registers
  logic [N-1:0] outData_q, outData_d;
  logic         sat_q, sat_d;

  logic accept;
  logic signed [ACC_W-1:0] biasExt;

  assign accept  = (state_q == ACCUM) && in_valid;
  assign biasExt = ACC_W'($signed(bias));

  // Full-width signed product of one lane
  function automatic logic signed [2*N-1:0] laneMul(
    input logic signed [N-1:0] w,
    input logic signed [N-1:0] d
  );
    return w * d;
  endfunction

  // Next-state logic. Each state's exit condition is its only transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start)              state_d = ACCUM;
      ACCUM:  if (accept && in_last)  state_d = DRAIN;
      DRAIN:  if (rndValid_q)         state_d = RESULT;
      RESULT: if (out_ready)          state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Handshake and status outputs are decoded straight from the state
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == RESULT);
    busy      = (state_q != IDLE);
    out_data  = outData_q;
    sat       = sat_q;
  end

  // P1 next values. A bubble or a masked lane yields a zero product.
  always_comb begin
    p1Valid_d = accept;
    p1Last_d  = accept && in_last;
    for (int l = 0; l < LANES; l++) begin
      p1Prod_d[l] = '0;
      if (accept && in_mask[l])
        p1Prod_d[l] = laneMul(weight[l*N +: N], data[l*N +: N]);
    end
  end

  // P1 product registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      p1Valid_q <= 1'b0;
      p1Last_q  <= 1'b0;
      for (int l = 0; l < LANES; l++) p1Prod_q[l] <= '0;
    end else begin
      p1Valid_q <= p1Valid_d;
      p1Last_q  <= p1Last_d;
      for (int l = 0; l < LANES; l++) p1Prod_q[l] <= p1Prod_d[l];
    end
  end

  // P2 adder tree. Each product is sign-extended to accumulator width first.
  always_comb begin
    p2Sum_d   = '0;
    p2Valid_d = p1Valid_q;
    p2Last_d  = p1Last_q;
    if (p1Valid_q) begin
      for (int l = 0; l < LANES; l++)
        p2Sum_d = p2Sum_d + ACC_W'(p1Prod_q[l]);
    end
  end

  // P2 sum registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      p2Sum_q   <= '0;
      p2Valid_q <= 1'b0;
      p2Last_q  <= 1'b0;
    end else begin
      p2Sum_q   <= p2Sum_d;
      p2Valid_q <= p2Valid_d;
      p2Last_q  <= p2Last_d;
    end
  end

  // P3 accumulator. A start pulse in IDLE preloads the bias aligned to the
  // product Q format. Afterwards each valid sum is added; bubbles add nothing.
  always_comb begin
    acc_d     = acc_q;
    accDone_d = p2Valid_q && p2Last_q;
    if ((state_q == IDLE) && start)
      acc_d = biasExt <<< FRAC;
    else if (p2Valid_q)
      acc_d = acc_q + p2Sum_q;
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q     <= '0;
      accDone_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      accDone_q <= accDone_d;
    end
  end

  // Round half-up and rescale once the final sum has been accumulated
  always_comb begin
    rnd_d      = rnd_q;
    rndValid_d = accDone_q;
    if (accDone_q)
      rnd_d = (acc_q + HALF) >>> FRAC;
  end

  // Rounding stage register
  always_ff @(posedge clk) begin
    if (!rst) begin
      rnd_q      <= '0;
      rndValid_q <= 1'b0;
    end else begin
      rnd_q      <= rnd_d;
      rndValid_q <= rndValid_d;
    end
  end

  // Saturate the rounded value to N bits. The result registers update only
  // on the cycle that enters RESULT, so they stay stable while it is held.
  always_comb begin
    outData_d = outData_q;
    sat_d     = sat_q;
    if (rndValid_q) begin
      if (rnd_q > SAT_MAX) begin
        outData_d = SAT_MAX[N-1:0];
        sat_d     = 1'b1;
      end else if (rnd_q < SAT_MIN) begin
        outData_d = SAT_MIN[N-1:0];
        sat_d     = 1'b1;
      end else begin
        outData_d = rnd_q[N-1:0];
        sat_d     = 1'b0;
      end
`ifdef NEURON_MAC_RELU_EN
      if (rnd_q[ACC_W-1])
        outData_d = '0;
`else
`endif
    end
  end

  // Result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      outData_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      outData_q <= outData_d;
      sat_q     <= sat_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac_array.sv
// Self-checking bench for neuron_mac_array (N=16, FRAC=8, LANES=4).
// Expected results come from a behavioural model and are queued when the last
// beat is driven. They are popped and compared when the DUT delivers a result.

module tb_neuron_mac_array;

  localparam int N     = 16;
  localparam int FRAC  = 8;
  localparam int LANES = 4;
  localparam int ACC_W = 48;

  logic              clk;
  logic              rst;
  logic              start;
  logic [N-1:0]      bias;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [LANES-1:0]  in_mask;
  logic [LANES*N-1:0] weight;
  logic [LANES*N-1:0] data;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      out_data;
  logic              sat;
  logic              busy;

  int checkCount;
  int passCount;
  longint modelAcc;
  logic [16:0] lastExpected;
  logic [16:0] sbQueue [$];

  neuron_mac_array #(.N(N), .FRAC(FRAC), .LANES(LANES), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_mask(in_mask), .weight(weight), .data(data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat(sat), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    else
      passCount++;
  endtask

  function automatic logic [63:0] rep(input logic [15:0] v);
    return {4{v}};
  endfunction

  // Model: round half-up, rescale, saturate (and optional ReLU)
  function automatic logic [16:0] modelResult(input longint acc);
    longint r;
    logic [15:0] d;
    logic s;
    r = (acc + 128) >>> FRAC;
    if (r > 32767) begin
      d = 16'h7FFF; s = 1'b1;
    end else if (r < -32768) begin
      d = 16'h8000; s = 1'b1;
    end else begin
      d = r[15:0]; s = 1'b0;
    end
`ifdef NEURON_MAC_RELU_EN
    if (r < 0) d = 16'h0000;
`endif
    return {s, d};
  endfunction

  // Compare every delivered result against the head of the scoreboard
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sbQueue.size() == 0) begin
        checkOutput("sbUnexpected", 32'd1, 32'd0);
      end else begin
        logic [16:0] exp;
        exp = sbQueue.pop_front();
        checkOutput("outData", 32'(out_data), 32'(exp[15:0]));
        checkOutput("sat", 32'(sat), 32'(exp[16]));
      end
    end
  end

  task automatic startNeuron(input logic signed [15:0] b);
    start = 1'b1;
    bias  = b;
    @(posedge clk); #1;
    start = 1'b0;
    modelAcc = longint'(b) * 256;
  endtask

  // Drive one beat; the bench accepts only while in ACCUM, where in_ready=1
  task automatic sendBeat(input logic [63:0] w, input logic [63:0] d,
                          input logic [3:0] m, input logic last, input int gap);
    in_valid = 1'b1;
    weight   = w;
    data     = d;
    in_mask  = m;
    in_last  = last;
    checkOutput("inReadyBeat", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int l = 0; l < LANES; l++)
      if (m[l])
        modelAcc += longint'($signed(w[l*16 +: 16])) * longint'($signed(d[l*16 +: 16]));
    if (last) begin
      lastExpected = modelResult(modelAcc);
      sbQueue.push_back(lastExpected);
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      checkOutput("inReadyGap", 32'(in_ready), 32'd1);
    end
  endtask

  // Bounded wait for out_valid; counts edges after the last accepted beat
  task automatic waitResult();
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    checkOutput("latency", 32'(cnt), 32'd4);
  endtask

  // One complete neuron: start, beats (last on the final one), result
  task automatic applyStimulus(input logic signed [15:0] b, input logic [63:0] w,
                               input logic [63:0] d, input logic [3:0] m,
                               input int beats, input int gap, input int hold);
    startNeuron(b);
    for (int i = 0; i < beats; i++)
      sendBeat(w, d, m, (i == beats - 1), (i == beats - 1) ? 0 : gap);
    if (hold > 0) out_ready = 1'b0;
    waitResult();
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("holdValid", 32'(out_valid), 32'd1);
      checkOutput("holdData", 32'(out_data), 32'(lastExpected[15:0]));
      checkOutput("holdReady", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("validDrop", 32'(out_valid), 32'd0);
    checkOutput("idleBusy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; bias = '0; in_valid = 1'b0; in_last = 1'b0;
    in_mask = '0; weight = '0; data = '0; out_ready = 1'b1;
    checkCount = 0; passCount = 0; modelAcc = 0; lastExpected = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstReady", 32'(in_ready), 32'd0);
    checkOutput("rstValid", 32'(out_valid), 32'd0);
    checkOutput("rstData", 32'(out_data), 32'd0);
    checkOutput("rstSat", 32'(sat), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic: 4 x 256*512 -> 2048
    applyStimulus(16'sd0, rep(16'd256), rep(16'd512), 4'b1111, 1, 0, 0);
    // Mask and bias -> 768
    applyStimulus(16'sd256, rep(16'd256), rep(16'd256), 4'b0101, 1, 0, 0);
    // Multi-beat with gaps -> 3072
    applyStimulus(16'sd0, rep(16'd256), rep(16'd256), 4'b1111, 3, 2, 0);
    // Positive and negative saturation
    applyStimulus(16'sd0, rep(16'h7FFF), rep(16'h7FFF), 4'b1111, 4, 0, 0);
    applyStimulus(16'sd0, rep(16'h8000), rep(16'h7FFF), 4'b1111, 1, 0, 0);
    // Rounding: 128/256 rounds up, 127/256 rounds down
    applyStimulus(16'sd0, rep(16'd1), rep(16'd128), 4'b0001, 1, 0, 0);
    applyStimulus(16'sd0, rep(16'd1), rep(16'd127), 4'b0001, 1, 0, 0);
    // Negative in-range value, fully masked last beat with a bias
    applyStimulus(-16'sd300, rep(16'd256), rep(16'hFF00), 4'b0011, 1, 1, 0);
    applyStimulus(16'sd512, rep(16'd9), rep(16'd9), 4'b0000, 1, 0, 0);
    // Backpressure: result held for 5 cycles
    applyStimulus(16'sd100, rep(16'd300), rep(16'd200), 4'b1011, 2, 1, 5);

    // Reset mid-accumulation discards the neuron
    startNeuron(16'sd1000);
    sendBeat(rep(16'h7000), rep(16'h7000), 4'b1111, 1'b0, 0);
    in_valid = 1'b1; weight = rep(16'h7000); data = rep(16'h7000);
    in_mask = 4'b1111;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortValid", 32'(out_valid), 32'd0);
    checkOutput("abortReady", 32'(in_ready), 32'd0);
    // A beat offered in IDLE is ignored
    in_valid = 1'b1; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    checkOutput("idleIgnore", 32'(busy), 32'd0);
    applyStimulus(16'sd0, rep(16'd256), rep(16'd256), 4'b0110, 1, 0, 0);

    checkOutput("sbDrained", 32'(sbQueue.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Global time bound so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/neuron_mac_array.md
Name: neuron_mac_array

Overview:
- Multi-lane, pipelined multiply-accumulate engine for one neuron output.
- Each accepted beat carries LANES weight/input pairs with a per-lane enable mask. Products are summed and accumulated onto a preloaded bias.
- Result is rounded, rescaled by FRAC and saturated back to N bits.
- Sits between the weight/activation fetch logic and the layer output buffer; successor to the single-lane MAC/ACC pair.

Parameters:
- N, 16, signed data/weight/output width (two's complement)
- FRAC, 8, fractional bits of the Q format; 0 <= FRAC < N
- LANES, 4, products per beat
- ACC_W, 48, accumulator width; must be >= 2*N + clog2(LANES) + 8

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- start  in  1  one-cycle pulse in IDLE: load bias, begin a new neuron
- bias  in  N  signed bias in Q(N-FRAC).FRAC, sampled when start is accepted
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_last  in  1  marks the final beat of the neuron
- in_mask  in  LANES  lane enables; a 0 bit forces that lane's product to 0
- weight  in  LANES*N  packed signed weights, lane 0 in bits [N-1:0]
- data  in  LANES*N  packed signed activations, same packing
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  N  rounded, saturated result
- sat  out  1  result was clipped; valid with out_valid
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0 at an edge): state IDLE; in_ready=0, out_valid=0, out_data=0, sat=0, busy=0; accumulator and all pipeline registers cleared, pipeline valid bits cleared.
- Reset applies regardless of state, including mid-accumulation or while out_valid is held. The in-flight neuron is discarded.
- FSM states: IDLE, ACCUM, DRAIN, RESULT.
- IDLE:
  - start=1 -> acc <= sign_extend(bias) << FRAC; go to ACCUM.
  - in_valid is ignored in IDLE.
- ACCUM:
  - in_ready=1.
  - Each accepted beat launches into the pipeline.
  - Accepting a beat with in_last=1 -> go to DRAIN; in_ready drops the next cycle.
  - start is ignored in every state except IDLE.
- Pipeline stages:
  - P1 registers LANES full-width 2N-bit signed products, masked.
  - P2 registers the sign-extended adder-tree sum.
  - P3 performs acc <= acc + sum.
  - Gaps in in_valid insert bubbles; a bubble adds nothing.
- DRAIN:
  - Wait until P1/P2 are empty and the last sum has been added.
  - Then register out_data and sat, and go to RESULT.
- RESULT:
  - out_valid=1; out_data and sat stay stable until out_ready=1.
  - Handshake -> IDLE. out_valid drops the next cycle.
  - start in the same cycle as the handshake is ignored.
- Latency: out_valid rises exactly 4 clock edges after the edge accepting the last beat, when out_ready imposes no stall.
- Throughput: one beat per clock in ACCUM.
- Rescale (when FRAC>0):
  - r = (acc + 2^(FRAC-1)) >>> FRAC, arithmetic shift, round-half-up.
  - When FRAC=0: r = acc.
- Saturation:
  - r > 2^(N-1)-1 -> out_data = 0x7FFF (for N=16), sat=1.
  - r < -2^(N-1) -> out_data = 0x8000, sat=1.
  - Otherwise out_data = r[N-1:0], sat=0.
- Accumulator overflow beyond ACC_W wraps (two's complement); this is precluded by the ACC_W sizing rule for up to 256 beats.
- A neuron with zero data beats is not possible: in_last is required to leave ACCUM.
- in_mask=0 with in_last=1 is legal and ends the neuron.

Optional Feature:
- Macro: NEURON_MAC_RELU_EN.
- Defined: after saturation, a negative result gives out_data=0. sat still reflects clipping at the negative limit.
- Undefined: signed output passes through unchanged. No extra logic or ports in either case.

Test Plan:
- Basic, N=16, FRAC=8, LANES=4:
  - Stimulus: bias=0; one beat, mask=4'b1111, all weights 256, all data 512, last=1.
  - Required: out_data=2048, sat=0, out_valid exactly 4 edges after acceptance.
- Mask and bias:
  - Stimulus: bias=256; mask=4'b0101, weights 256, data 256, last=1.
  - Required: out_data=768.
- Multi-beat with gaps:
  - Stimulus: 3 beats (weights 256, data 256, full mask) with in_valid low 2 cycles between beats.
  - Required: out_data=3072; in_ready=1 throughout ACCUM.
- Saturation:
  - Stimulus: 4 beats of weights 0x7FFF, data 0x7FFF.
  - Required: out_data=0x7FFF, sat=1.
  - Stimulus: weights 0x8000, data 0x7FFF.
  - Required: out_data=0x8000, sat=1; 0 when NEURON_MAC_RELU_EN is defined.
- Rounding:
  - Stimulus: lane0 weight=1, data=128, other lanes masked, bias=0.
  - Required: out_data=1.
  - Stimulus: data=127.
  - Required: out_data=0.
- Backpressure and reset:
  - Stimulus: hold out_ready=0 for 5 cycles.
  - Required: out_data and out_valid stable, in_ready=0.
  - Stimulus: rst=0 for one edge mid-ACCUM.
  - Required: next cycle busy=0, out_valid=0; a following start/beat sequence yields the correct result, with no leftover from the aborted neuron.
